// File: rtl/adder_sweep_pkg.sv
// adder_sweep_pkg: shared definitions for the adder sweep sequencer.
//   - FSM state encodings (S_IDLE, S_RUN, S_DONE) and the state type.
//   - Width helpers: vector index width (2*WIDTH+1) and error counter
//     width (2*WIDTH+2), plus their values for the default WIDTH of 2.
package adder_sweep_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int vec_w(input int width);
    return 2 * width + 1;
  endfunction

  function automatic int cnt_w(input int width);
    return 2 * width + 2;
  endfunction

  localparam int DEFAULT_WIDTH = 2;
  localparam int VEC_W = 2 * DEFAULT_WIDTH + 1;
  localparam int CNT_W = 2 * DEFAULT_WIDTH + 2;

endpackage

// File: rtl/adder_sweep_sequencer_sweep_counter.sv
// sweep_counter: dwell counter and vector index for the adder sweep.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear_i         reload index 0 / dwell 0 (sweep accepted)
//   run_i           sweep running; dwell counts and the index advances
//   idx_o           current vector index {a, b, cin}
//   sample_pulse_o  running and dwell == SETTLE
//   last_pulse_o    running, final vector, final dwell cycle
module sweep_counter #(
  parameter int VEC_W  = 5,
  parameter int DWELL  = 10,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             run_i,
  output logic [VEC_W-1:0] idx_o,
  output logic             sample_pulse_o,
  output logic             last_pulse_o
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0] SETTLE_IDX = DW_W'(SETTLE);

  logic [DW_W-1:0]  dwell_q, dwell_d;
  logic [VEC_W-1:0] idx_q, idx_d;
  logic             dwell_end;

  assign dwell_end = (dwell_q == DWELL_LAST);

  always_comb begin
    dwell_d = dwell_q;
    idx_d   = idx_q;
    if (clear_i) begin
      dwell_d = '0;
      idx_d   = '0;
    end else if (run_i) begin
      if (dwell_end) begin
        // Next vector starts on the same edge: no idle gap between vectors.
        dwell_d = '0;
        idx_d   = idx_q + 1'b1;
      end else begin
        dwell_d = dwell_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      idx_q   <= '0;
    end else begin
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  assign idx_o          = idx_q;
  assign sample_pulse_o = run_i && (dwell_q == SETTLE_IDX);
  assign last_pulse_o   = run_i && dwell_end && (&idx_q);

endmodule

// File: rtl/adder_sweep_sequencer.sv
// adder_sweep_sequencer: drives every (a, b, cin) combination into an
// external adder, holds each for DWELL cycles, samples {cout, sum} once per
// vector at dwell == SETTLE and tallies mismatches.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle sweep request
//   a_out, b_out, cin_out  operands to the adder (0 outside a sweep)
//   sum_in, cout_in        adder result
//   busy, done     sweep running / sweep complete (held)
//   err, err_count, fail_vec  mismatch flag, saturating count, first failing {a,b,cin}
//   dbg_state_o    current FSM state
//
// Handshake: start is a single-cycle request with no ready; it is accepted
// on any edge where the FSM is in IDLE or DONE and rst is low, and is
// silently dropped while busy.
module adder_sweep_sequencer
  import adder_sweep_pkg::*;
#(
  parameter int WIDTH  = 2,
  parameter int DWELL  = 10,
  parameter int SETTLE = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a_out,
  output logic [WIDTH-1:0]     b_out,
  output logic                 cin_out,
  input  logic [WIDTH-1:0]     sum_in,
  input  logic                 cout_in,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     fail_vec,
  output state_t               dbg_state_o
);

  localparam int VW = vec_w(WIDTH);
  localparam int CW = cnt_w(WIDTH);

  state_t        state_q, state_d;
  logic          accept;
  logic          running;
  logic [VW-1:0] idx;
  logic          sample_pulse, last_pulse;
  logic [WIDTH-1:0] cur_a, cur_b;
  logic          cur_cin;
  logic [WIDTH:0] exp_sum;
  logic          mismatch;

  logic          err_q, err_d;
  logic [CW-1:0] err_count_q, err_count_d;
  logic [VW-1:0] fail_vec_q, fail_vec_d;

  assign accept  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign running = (state_q == S_RUN);

  sweep_counter #(
    .VEC_W  (VW),
    .DWELL  (DWELL),
    .SETTLE (SETTLE)
  ) u_counter (
    .clk            (clk),
    .rst            (rst),
    .clear_i        (accept),
    .run_i          (running),
    .idx_o          (idx),
    .sample_pulse_o (sample_pulse),
    .last_pulse_o   (last_pulse)
  );

  // Index packing: a in the MSBs, b in the middle, cin in the LSB.
  assign cur_a   = idx[VW-1 -: WIDTH];
  assign cur_b   = idx[WIDTH:1];
  assign cur_cin = idx[0];

  // Full WIDTH+1 result so the carry-out is checked too.
  assign exp_sum  = {1'b0, cur_a} + {1'b0, cur_b} + {{WIDTH{1'b0}}, cur_cin};
  assign mismatch = ({cout_in, sum_in} != exp_sum);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (last_pulse) state_d = S_DONE;
      S_DONE:  if (accept) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    a_out   = '0;
    b_out   = '0;
    cin_out = 1'b0;
    case (state_q)
      S_RUN: begin
        busy    = 1'b1;
        a_out   = cur_a;
        b_out   = cur_b;
        cin_out = cur_cin;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Error bookkeeping: one comparison per vector, at the sample pulse.
  always_comb begin
    err_d       = err_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    if (accept) begin
      err_d       = 1'b0;
      err_count_d = '0;
      fail_vec_d  = '0;
    end else if (sample_pulse && mismatch) begin
      err_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      if (!err_q) fail_vec_d = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      err_count_q <= '0;
      fail_vec_q  <= '0;
    end else begin
      err_q       <= err_d;
      err_count_q <= err_count_d;
      fail_vec_q  <= fail_vec_d;
    end
  end

  assign err         = err_q;
  assign err_count   = err_count_q;
  assign fail_vec    = fail_vec_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adder_sweep_sequencer.sv
module tb_adder_sweep_sequencer;
  import adder_sweep_pkg::*;

  localparam int WIDTH  = 2;
  localparam int DWELL  = 4;
  localparam int SETTLE = 1;
  localparam int NVEC   = 32;
  localparam int SWEEP  = NVEC * DWELL;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a_out, b_out, sum_in;
  logic             cin_out, cout_in;
  logic             busy, done, err;
  logic [5:0]       err_count;
  logic [4:0]       fail_vec;
  state_t           dbg_state;

  adder_sweep_sequencer #(.WIDTH(WIDTH), .DWELL(DWELL), .SETTLE(SETTLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a_out       (a_out),
    .b_out       (b_out),
    .cin_out     (cin_out),
    .sum_in      (sum_in),
    .cout_in     (cout_in),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .err_count   (err_count),
    .fail_vec    (fail_vec),
    .dbg_state_o (dbg_state)
  );

  // Adder model: 0 ideal, 1 cout stuck at 0, 2 sum[0] stuck at 0.
  int model_mode = 0;
  logic [WIDTH:0] model_res;
  always_comb begin
    model_res = {1'b0, a_out} + {1'b0, b_out} + {{WIDTH{1'b0}}, cin_out};
    if (model_mode == 1) model_res[WIDTH] = 1'b0;
    if (model_mode == 2) model_res[0] = 1'b0;
    sum_in  = model_res[WIDTH-1:0];
    cout_in = model_res[WIDTH];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fill_expected();
    exp_q.delete();
    for (int v = 0; v < NVEC; v++) exp_q.push_back(5'(v));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " err"}, 32'(err), 0);
    check({tag, " err_count"}, 32'(err_count), 0);
    check({tag, " fail_vec"}, 32'(fail_vec), 0);
    check({tag, " vector"}, 32'({a_out, b_out, cin_out}), 0);
    check({tag, " state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Pulse start for one edge; afterwards the accept edge has passed.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs a sweep from the accept edge to done. poke_n >= 0 pulses start
  // mid-sweep at that cycle offset; abort_n >= 0 returns early there.
  task automatic run_sweep(input int poke_n, input int abort_n, output int cycles);
    logic [4:0] e;
    int n;
    fill_expected();
    pulse_start();
    check("accept busy", 32'(busy), 1);
    check("accept done", 32'(done), 0);
    check("accept err", 32'(err), 0);
    check("accept err_count", 32'(err_count), 0);
    check("accept fail_vec", 32'(fail_vec), 0);
    n = 0;
    cycles = -1;
    while (n <= 4 * SWEEP) begin
      if (done) begin
        cycles = n;
        break;
      end
      if (n == abort_n) return;
      if (busy && (n % DWELL == 0)) begin
        if (exp_q.size() == 0) check("extra vector", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("vector", 32'({a_out, b_out, cin_out}), 32'(e));
        end
      end
      start = (n == poke_n);
      @(posedge clk);
      #1 n++;
      start = 1'b0;
    end
    if (cycles < 0) check("done timeout", 0, 1);
    check("vectors consumed", 32'(exp_q.size()), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int         mode;
    logic       exp_err;
    logic [5:0] exp_count;
    logic [4:0] exp_fail;
  } vec_t;

  vec_t tbl[3];

  initial begin
    int cyc;

    tbl[0] = '{mode: 0, exp_err: 1'b0, exp_count: 6'd0,  exp_fail: 5'b00000};
    tbl[1] = '{mode: 2, exp_err: 1'b1, exp_count: 6'd16, exp_fail: 5'b00001};
    tbl[2] = '{mode: 1, exp_err: 1'b1, exp_count: 6'd16, exp_fail: 5'b00111};

    do_reset();
    check_all_zero("reset");

    for (int i = 0; i < 3; i++) begin
      model_mode = tbl[i].mode;
      run_sweep(-1, -1, cyc);
      check("sweep cycles", 32'(cyc), SWEEP);
      check("done", 32'(done), 1);
      check("busy", 32'(busy), 0);
      check("err", 32'(err), 32'(tbl[i].exp_err));
      check("err_count", 32'(err_count), 32'(tbl[i].exp_count));
      check("fail_vec", 32'(fail_vec), 32'(tbl[i].exp_fail));
      check("done vector", 32'({a_out, b_out, cin_out}), 0);
    end

    // Results held in DONE (last sweep had cout stuck at 0).
    repeat (5) @(posedge clk);
    #1;
    check("held done", 32'(done), 1);
    check("held err_count", 32'(err_count), 16);
    check("held fail_vec", 32'(fail_vec), 5'b00111);

    // Restart from DONE with the ideal model: accept edge clears results.
    model_mode = 0;
    run_sweep(-1, -1, cyc);
    check("restart cycles", 32'(cyc), SWEEP);
    check("restart err", 32'(err), 0);
    check("restart err_count", 32'(err_count), 0);

    // Start while busy at vector 5 is ignored.
    run_sweep(5 * DWELL, -1, cyc);
    check("busy-start cycles", 32'(cyc), SWEEP);
    check("busy-start err_count", 32'(err_count), 0);

    // Reset mid-sweep at vector 10, dwell 2.
    model_mode = 1;
    run_sweep(-1, 10 * DWELL + 2, cyc);
    check("pre-abort vector", 32'({a_out, b_out, cin_out}), 32'(5'd10));
    check("pre-abort err", 32'(err), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check_all_zero("abort");

    // start and rst together: rst wins.
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    check_all_zero("rst+start");

    model_mode = 0;
    run_sweep(-1, -1, cyc);
    check("post-abort cycles", 32'(cyc), SWEEP);
    check("post-abort err", 32'(err), 0);
    check("post-abort err_count", 32'(err_count), 0);
    check("post-abort fail_vec", 32'(fail_vec), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
